inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction fetch stage of the RV64 core: owns the fetch PC, issues in-order word reads to
//  instruction memory and presents {PC, instruction} pairs to the decode stage via valid/ready.
//  Producer side of decode's i_PC_64/i_Inst_32 inputs. Handles redirects (branch/jump/trap) by
//  flushing buffered words and discarding in-flight responses.
// PARAMETERS
//  RESET_PC  64'h0000_0000_8000_0000  fetch PC loaded on reset; bits [1:0] must be 0
//  DEPTH     2                        instruction buffer entries = max buffered + outstanding (2..8)
// PORTS
//  i_Clk               in   1   clock, all state on rising edge
//  i_Rst               in   1   synchronous reset, active-high
//  o_IMemReqValid_1    out  1   fetch request valid
//  i_IMemReqReady_1    in   1   memory accepts request this cycle
//  o_IMemReqAddr_64    out  64  fetch address, [1:0]=0
//  i_IMemRespValid_1   in   1   read data valid (in order, one per accepted request, >=1 cycle later)
//  i_IMemRespData_32   in   32  instruction word
//  i_Redirect_1        in   1   flush and restart at i_RedirectPC_64
//  i_RedirectPC_64     in   64  new fetch PC; bits [1:0] ignored (forced 0)
//  o_InstValid_1       out  1   o_PC_64/o_Inst_32 valid toward decode
//  i_InstReady_1       in   1   decode consumes entry
//  o_PC_64             out  64  PC of presented instruction
//  o_Inst_32           out  32  presented instruction word
// BEHAVIOUR
//  - Reset (i_Rst=1 at edge): reqPC=respPC=RESET_PC; buffer empty; outstanding=stale=0;
//    o_IMemReqValid_1=0, o_InstValid_1=0, o_PC_64=RESET_PC, o_Inst_32=32'h0000_0013 (NOP).
//  - Credit rule: request asserted iff (buffered + outstanding) < DEPTH, or a request is pending.
//  - Request handshake: valid&ready at edge -> outstanding+1, reqPC+=4 (mod 2^64, wraps to 0).
//    Once asserted, valid and address held stable until accepted (including across redirect).
//  - Response: if stale>0 -> stale-1, word dropped; else push {respPC, data}, respPC+=4.
//    Pushed entry visible on o_InstValid_1 the cycle after the response (registered buffer).
//    Each response (kept or dropped) decrements outstanding.
//  - Buffer: FIFO of DEPTH; pop on o_InstValid_1&i_InstReady_1; push and pop same cycle legal.
//    Credit rule guarantees no push when full. o_PC_64/o_Inst_32 = head entry; hold when not popped.
//  - Redirect (i_Redirect_1=1 at edge), highest priority:
//    buffer emptied; reqPC=respPC={i_RedirectPC_64[63:2],2'b00};
//    stale = outstanding (after this cycle's accept/response updates) + 1 if a request is
//    pending-unaccepted (that request keeps old address, its response is dropped);
//    o_InstValid_1 forced 0 combinationally in the redirect cycle (no decode handshake counted);
//    response arriving in the redirect cycle is dropped. New-PC request earliest next cycle.
//  - Consecutive redirects: each re-targets PC; stale accumulates correctly.
//  - Response with outstanding=0 (protocol error, e.g. post-reset): ignored, no state change.
//  - Min latency: request at cycle N, response N+1, o_InstValid_1 at N+2.
//  - Reset mid-operation discards everything; memory side is reset by the same i_Rst.
// TESTING
//  1 Reset release, memory ready=1, 1-cycle response -> req addrs 8000_0000,8000_0004,...;
//    decode sees PC 8000_0000 inst X at 2nd cycle after first req, then back-to-back 1/cycle.
//  2 i_InstReady_1=0 held, DEPTH=2 -> exactly 2 requests issued, then valid low; buffer holds
//    both; ready=1 -> entries emerge in order, requests resume.
//  3 Redirect to 0000_1002 with 2 outstanding -> both responses dropped, next req addr
//    0000_1000, first decoded PC 0000_1000; no pre-redirect PC ever presented after redirect.
//  4 Redirect while request pending with ready=0 -> address unchanged until accept, its response
//    dropped, next request at redirect PC.
//  5 RESET_PC=FFFF_FFFF_FFFF_FFFC -> second request addr 0, o_PC_64 sequence FFFF..FFFC, 0.
//  6 i_Rst asserted mid-stream with entries buffered -> next cycle valid outputs 0, PC=RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word reads to instruction memory
// and hands {PC, instruction} pairs to decode through a small credit-managed FIFO.
module inst_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    output logic        o_IMemReqValid_1,
    input  logic        i_IMemReqReady_1,
    output logic [63:0] o_IMemReqAddr_64,
    input  logic        i_IMemRespValid_1,
    input  logic [31:0] i_IMemRespData_32,
    input  logic        i_Redirect_1,
    input  logic [63:0] i_RedirectPC_64,
    output logic        o_InstValid_1,
    input  logic        i_InstReady_1,
    output logic [63:0] o_PC_64,
    output logic [31:0] o_Inst_32
);

    localparam int          PTR_W = $clog2(DEPTH);
    localparam int          CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [63:0]      req_pc;
    logic [63:0]      resp_pc;
    logic [63:0]      pend_addr;
    logic             pend_q;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] stale;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [63:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];

    logic             pop;
    logic             push;
    logic             credit;
    logic             fresh_req;
    logic             req_fire;
    logic             resp_fire;
    logic             pend_nxt;
    logic [CNT_W:0]   in_use;
    logic [CNT_W-1:0] out_nxt;
    logic [63:0]      redirect_pc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign redirect_pc = i_RedirectPC_64 & ~64'h3;

    // A same-cycle pop frees a slot, so the next word can be requested while the head drains.
    assign in_use    = {1'b0, count} + {1'b0, outstanding} - {{CNT_W{1'b0}}, pop};
    assign credit    = in_use < (CNT_W + 1)'(DEPTH);
    assign fresh_req = credit & ~pend_q & ~i_Redirect_1 & ~i_Rst;

    assign o_IMemReqValid_1 = ~i_Rst & (pend_q | fresh_req);
    assign o_IMemReqAddr_64 = pend_q ? pend_addr : req_pc;
    assign req_fire         = o_IMemReqValid_1 & i_IMemReqReady_1;
    assign pend_nxt         = o_IMemReqValid_1 & ~i_IMemReqReady_1;

    // Responses with nothing outstanding are protocol noise and are ignored outright.
    assign resp_fire = i_IMemRespValid_1 & (outstanding != '0);
    assign push      = resp_fire & (stale == '0) & ~i_Redirect_1;
    assign out_nxt   = outstanding + CNT_W'(req_fire) - CNT_W'(resp_fire);

    assign o_InstValid_1 = (count != '0) & ~i_Redirect_1;
    assign pop           = o_InstValid_1 & i_InstReady_1;
    assign o_PC_64       = pc_mem[head];
    assign o_Inst_32     = inst_mem[head];

    // NOTE: sequential state uses non-blocking assignments only, so every read of a register
    // in this block sees its value from before the edge.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            req_pc      <= RESET_PC;
            resp_pc     <= RESET_PC;
            pend_addr   <= RESET_PC;
            pend_q      <= 1'b0;
            outstanding <= '0;
            stale       <= '0;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            // NOTE: the buffer storage is reset because the head slot drives o_PC_64/o_Inst_32
            // directly and must read RESET_PC/NOP straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= RESET_PC;
                inst_mem[i] <= NOP;
            end
        end else begin
            outstanding <= out_nxt;
            pend_q      <= pend_nxt;
            if (!pend_q)
                pend_addr <= req_pc;

            if (i_Redirect_1) begin
                req_pc  <= redirect_pc;
                resp_pc <= redirect_pc;
                count   <= '0;
                head    <= '0;
                tail    <= '0;
                // Every word still owed by memory, plus a request stuck on the old address, is junk.
                stale   <= out_nxt + CNT_W'(pend_nxt);
            end else begin
                if (fresh_req)
                    req_pc <= req_pc + 64'd4;
                if (resp_fire && stale != '0)
                    stale <= stale - CNT_W'(1);
                if (push) begin
                    pc_mem[tail]   <= resp_pc;
                    inst_mem[tail] <= i_IMemRespData_32;
                    tail           <= ptr_inc(tail);
                    resp_pc        <= resp_pc + 64'd4;
                end
                if (pop)
                    head <= ptr_inc(head);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: two instances (default reset PC and a wrapping reset PC)
// driven by a one-cycle-latency memory model.
module tb_inst_fetch;

    localparam logic [63:0] RST_PC  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_ready;
    logic        redir;
    logic [63:0] redir_pc;
    logic        inst_ready;

    logic        resp_v,   w_resp_v;
    logic [31:0] resp_d,   w_resp_d;
    logic        req_v,    w_req_v;
    logic [63:0] req_addr, w_req_addr;
    logic        inst_v,   w_inst_v;
    logic [63:0] pc,       w_pc;
    logic [31:0] inst,     w_inst;

    int          checks   = 0;
    int          failures = 0;
    bit          mem_on;
    logic [63:0] q1[$];
    logic [63:0] q2[$];

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(RST_PC), .DEPTH(2)) u_dut (
        .i_Clk(clk), .i_Rst(rst),
        .o_IMemReqValid_1(req_v), .i_IMemReqReady_1(req_ready), .o_IMemReqAddr_64(req_addr),
        .i_IMemRespValid_1(resp_v), .i_IMemRespData_32(resp_d),
        .i_Redirect_1(redir), .i_RedirectPC_64(redir_pc),
        .o_InstValid_1(inst_v), .i_InstReady_1(inst_ready),
        .o_PC_64(pc), .o_Inst_32(inst)
    );

    inst_fetch #(.RESET_PC(WRAP_PC), .DEPTH(2)) u_wrap (
        .i_Clk(clk), .i_Rst(rst),
        .o_IMemReqValid_1(w_req_v), .i_IMemReqReady_1(req_ready), .o_IMemReqAddr_64(w_req_addr),
        .i_IMemRespValid_1(w_resp_v), .i_IMemRespData_32(w_resp_d),
        .i_Redirect_1(redir), .i_RedirectPC_64(redir_pc),
        .o_InstValid_1(w_inst_v), .i_InstReady_1(inst_ready),
        .o_PC_64(w_pc), .o_Inst_32(w_inst)
    );

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: note accepted requests, step the edge, then drive this cycle's memory response.
    task automatic cyc();
        bit          a1, a2;
        logic [63:0] ad1, ad2;
        #1;
        a1  = req_v & req_ready;
        ad1 = req_addr;
        a2  = w_req_v & req_ready;
        ad2 = w_req_addr;
        @(posedge clk);
        #1;
        if (rst) begin
            q1.delete();
            q2.delete();
        end else begin
            if (a1) q1.push_back(ad1);
            if (a2) q2.push_back(ad2);
        end
        resp_v   = 1'b0;
        resp_d   = '0;
        w_resp_v = 1'b0;
        w_resp_d = '0;
        if (mem_on && q1.size() > 0) begin
            resp_v = 1'b1;
            resp_d = inst_of(q1.pop_front());
        end
        if (mem_on && q2.size() > 0) begin
            w_resp_v = 1'b1;
            w_resp_d = inst_of(q2.pop_front());
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; req_ready = 1'b0; redir = 1'b0; redir_pc = '0; inst_ready = 1'b0;
        resp_v = 1'b0; resp_d = '0; w_resp_v = 1'b0; w_resp_d = '0; mem_on = 1'b1;
        cyc();
        cyc();
        chk("rst_req_v", req_v, 0);
        chk("rst_inst_v", inst_v, 0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_inst", inst, NOP);
        chk("rst_wrap_pc", w_pc, WRAP_PC);

        // Streaming from reset with an always-ready memory and decode.
        rst = 1'b0; req_ready = 1'b1; inst_ready = 1'b1;
        #1;
        chk("s_c0_req_v", req_v, 1);
        chk("s_c0_addr", req_addr, 64'h8000_0000);
        chk("s_c0_inst_v", inst_v, 0);
        cyc();
        chk("s_c1_addr", req_addr, 64'h8000_0004);
        chk("s_c1_inst_v", inst_v, 0);
        cyc();
        chk("s_c2_inst_v", inst_v, 1);
        chk("s_c2_pc", pc, 64'h8000_0000);
        chk("s_c2_inst", inst, inst_of(64'h8000_0000));
        chk("s_c2_addr", req_addr, 64'h8000_0008);
        cyc();
        chk("s_c3_pc", pc, 64'h8000_0004);
        chk("s_c3_addr", req_addr, 64'h8000_000C);
        cyc();
        chk("s_c4_pc", pc, 64'h8000_0008);

        // Decode stalls with words buffered, then reset lands mid-stream.
        inst_ready = 1'b0;
        #1;
        chk("h_c4_req_v", req_v, 0);
        cyc();
        chk("h_c5_pc", pc, 64'h8000_0008);
        chk("h_c5_req_v", req_v, 0);
        cyc();
        chk("h_c6_inst_v", inst_v, 1);
        chk("h_c6_pc", pc, 64'h8000_0008);
        rst = 1'b1;
        cyc();
        chk("mrst_inst_v", inst_v, 0);
        chk("mrst_req_v", req_v, 0);
        chk("mrst_pc", pc, RST_PC);

        // Decode held off from reset: exactly two requests fill the buffer.
        rst = 1'b0;
        #1;
        chk("bp_a0_addr", req_addr, 64'h8000_0000);
        cyc();
        chk("bp_a1_req_v", req_v, 1);
        chk("bp_a1_addr", req_addr, 64'h8000_0004);
        cyc();
        chk("bp_a2_req_v", req_v, 0);
        chk("bp_a2_pc", pc, 64'h8000_0000);
        cyc();
        chk("bp_a3_req_v", req_v, 0);
        cyc();
        chk("bp_a4_req_v", req_v, 0);
        chk("bp_a4_inst", inst, inst_of(64'h8000_0000));
        inst_ready = 1'b1;
        #1;
        chk("bp_a4_resume_v", req_v, 1);
        chk("bp_a4_resume_addr", req_addr, 64'h8000_0008);
        cyc();
        chk("bp_a5_pc", pc, 64'h8000_0004);
        cyc();
        chk("bp_a6_pc", pc, 64'h8000_0008);

        // Redirect with two requests in flight and memory withholding responses.
        rst = 1'b1;
        cyc();
        rst = 1'b0; mem_on = 1'b0;
        #1;
        chk("rd_b0_addr", req_addr, 64'h8000_0000);
        cyc();
        chk("rd_b1_addr", req_addr, 64'h8000_0004);
        cyc();
        chk("rd_b2_req_v", req_v, 0);
        redir = 1'b1; redir_pc = 64'h0000_0000_0000_1002; mem_on = 1'b1;
        #1;
        chk("rd_b2_inst_v", inst_v, 0);
        cyc();
        redir = 1'b0;
        #1;
        chk("rd_b3_req_v", req_v, 0);
        chk("rd_b3_inst_v", inst_v, 0);
        cyc();
        chk("rd_b4_req_v", req_v, 1);
        chk("rd_b4_addr", req_addr, 64'h0000_1000);
        chk("rd_b4_inst_v", inst_v, 0);
        cyc();
        chk("rd_b5_inst_v", inst_v, 0);
        chk("rd_b5_addr", req_addr, 64'h0000_1004);
        cyc();
        chk("rd_b6_inst_v", inst_v, 1);
        chk("rd_b6_pc", pc, 64'h0000_1000);
        chk("rd_b6_inst", inst, inst_of(64'h0000_1000));

        // Redirect while a request waits on memory: the old address stays until accepted.
        req_ready = 1'b0;
        #1;
        chk("rp_b6_req_v", req_v, 1);
        chk("rp_b6_addr", req_addr, 64'h0000_1008);
        cyc();
        chk("rp_b7_addr", req_addr, 64'h0000_1008);
        chk("rp_b7_pc", pc, 64'h0000_1004);
        redir = 1'b1; redir_pc = 64'h0000_0000_0000_2000;
        #1;
        chk("rp_b7_inst_v", inst_v, 0);
        chk("rp_b7_hold_addr", req_addr, 64'h0000_1008);
        cyc();
        redir = 1'b0;
        #1;
        chk("rp_b8_req_v", req_v, 1);
        chk("rp_b8_addr", req_addr, 64'h0000_1008);
        req_ready = 1'b1;
        cyc();
        chk("rp_b9_addr", req_addr, 64'h0000_2000);
        chk("rp_b9_inst_v", inst_v, 0);
        cyc();
        chk("rp_b10_inst_v", inst_v, 0);
        cyc();
        chk("rp_b11_inst_v", inst_v, 1);
        chk("rp_b11_pc", pc, 64'h0000_2000);
        chk("rp_b11_inst", inst, inst_of(64'h0000_2000));

        // A response with nothing outstanding must leave the buffer untouched.
        rst = 1'b1;
        cyc();
        rst = 1'b0; req_ready = 1'b0; resp_v = 1'b1; resp_d = 32'hDEAD_BEEF;
        cyc();
        chk("orph_inst_v", inst_v, 0);
        chk("orph_inst", inst, NOP);
        chk("orph_req_v", req_v, 1);
        chk("orph_addr", req_addr, 64'h8000_0000);

        // Fetch PC wrapping past 2^64.
        rst = 1'b1;
        cyc();
        rst = 1'b0; req_ready = 1'b1; inst_ready = 1'b1;
        #1;
        chk("wr_w0_addr", w_req_addr, WRAP_PC);
        cyc();
        chk("wr_w1_addr", w_req_addr, 64'h0);
        cyc();
        chk("wr_w2_inst_v", w_inst_v, 1);
        chk("wr_w2_pc", w_pc, WRAP_PC);
        chk("wr_w2_inst", w_inst, inst_of(WRAP_PC));
        cyc();
        chk("wr_w3_pc", w_pc, 64'h0);
        chk("wr_w3_inst", w_inst, inst_of(64'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
